// File: rtl/brnch_track_ctrl.sv
// Two-entry in-order branch tracker: tags new branches, gathers out-of-order
// resolutions, retires in program order and drives redirect/stall on mispredicts.
module brnch_track_ctrl #(
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  alloc_vld,
  input  logic [15:0] alloc_pc1,
  input  logic [15:0] alloc_pc0,
  input  logic [1:0]  alloc_pred,
  output logic        alloc_tag1,
  output logic        alloc_tag0,
  input  logic        res_vld,
  input  logic        res_tag,
  input  logic        res_taken,
  input  logic [15:0] res_target,
  output logic        decr_count,
  output logic        mispred_num,
  output logic        redirect_vld,
  output logic [15:0] redirect_pc,
  output logic        stall_fetch,
  output logic        full,
  output logic        bpred_upd_vld,
  output logic [15:0] bpred_upd_pc,
  output logic        bpred_upd_taken,
  output logic        alloc_drop
);

  typedef enum logic {NORM, RECOV} state_t;

  state_t      state_q, state_d;
  logic [2:0]  rcnt_q, rcnt_d;
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  valid_q, valid_d;
  logic [1:0]  pred_q, pred_d;
  logic [1:0]  resolved_q, resolved_d;
  logic [1:0]  taken_q, taken_d;
  logic [15:0] pc_q [2];
  logic [15:0] pc_d [2];
  logic [15:0] target_q [2];
  logic [15:0] target_d [2];

  logic        decr_q, decr_d;
  logic        mnum_q, mnum_d;
  logic        redir_vld_q, redir_vld_d;
  logic [15:0] redir_pc_q, redir_pc_d;
  logic        upd_vld_q, upd_vld_d;
  logic [15:0] upd_pc_q, upd_pc_d;
  logic        upd_taken_q, upd_taken_d;
  logic        drop_q, drop_d;

  logic        res_hit, hd_taken, retire, mispred;
  logic [15:0] hd_target;
  logic [1:0]  n_req, n_free, n_acc;

  // The first request always lands at head+count; a lone younger request is compacted there too.
  assign alloc_tag1 = head_q ^ count_q[0];
  assign alloc_tag0 = alloc_vld[1] ? ~alloc_tag1 : alloc_tag1;

  assign res_hit   = res_vld && (res_tag == head_q) && valid_q[head_q];
  assign hd_taken  = res_hit ? res_taken  : taken_q[head_q];
  assign hd_target = res_hit ? res_target : target_q[head_q];
  assign retire    = (state_q == NORM) && valid_q[head_q] && (resolved_q[head_q] || res_hit);
  assign mispred   = retire && (hd_taken != pred_q[head_q]);

  assign n_req  = {1'b0, alloc_vld[1]} + {1'b0, alloc_vld[0]};
  assign n_free = 2'd2 - count_q;
  assign n_acc  = (n_req > n_free) ? n_free : n_req;

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    head_d      = head_q;
    count_d     = count_q;
    valid_d     = valid_q;
    pred_d      = pred_q;
    resolved_d  = resolved_q;
    taken_d     = taken_q;
    pc_d        = pc_q;
    target_d    = target_q;
    decr_d      = 1'b0;
    mnum_d      = 1'b0;
    redir_vld_d = 1'b0;
    redir_pc_d  = redir_pc_q;
    upd_vld_d   = 1'b0;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = 1'b0;
    drop_d      = 1'b0;

    case (state_q)
      NORM: begin
        if (res_vld && valid_q[res_tag]) begin
          resolved_d[res_tag] = 1'b1;
          taken_d[res_tag]    = res_taken;
          target_d[res_tag]   = res_target;
        end
        if (retire) begin
          decr_d      = 1'b1;
          upd_vld_d   = 1'b1;
          upd_pc_d    = pc_q[head_q];
          upd_taken_d = hd_taken;
          if (mispred) begin
            valid_d     = 2'b00;
            resolved_d  = 2'b00;
            count_d     = 2'd0;
            mnum_d      = valid_q[~head_q];
            redir_vld_d = 1'b1;
            redir_pc_d  = hd_taken ? hd_target : pc_q[head_q] + 16'd1;
            drop_d      = |alloc_vld;
            state_d     = RECOV;
            rcnt_d      = 3'(RECOVER_CYC - 1);
          end else begin
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
            head_d             = ~head_q;
            count_d            = 2'(count_q - 2'd1);
          end
        end
        // Free slots are counted before this edge's retire, so a full table never refills same-cycle.
        if (!mispred) begin
          if (n_acc != 2'd0) begin
            valid_d[alloc_tag1]    = 1'b1;
            resolved_d[alloc_tag1] = 1'b0;
            taken_d[alloc_tag1]    = 1'b0;
            target_d[alloc_tag1]   = 16'h0000;
            pc_d[alloc_tag1]       = alloc_vld[1] ? alloc_pc1 : alloc_pc0;
            pred_d[alloc_tag1]     = alloc_vld[1] ? alloc_pred[1] : alloc_pred[0];
          end
          if (n_acc == 2'd2) begin
            valid_d[~alloc_tag1]    = 1'b1;
            resolved_d[~alloc_tag1] = 1'b0;
            taken_d[~alloc_tag1]    = 1'b0;
            target_d[~alloc_tag1]   = 16'h0000;
            pc_d[~alloc_tag1]       = alloc_pc0;
            pred_d[~alloc_tag1]     = alloc_pred[0];
          end
          count_d = 2'(count_d + n_acc);
          drop_d  = (n_req > n_free);
        end
      end
      RECOV: begin
        drop_d = |alloc_vld;
        if (rcnt_q == 3'd0) state_d = NORM;
        else                rcnt_d  = rcnt_q - 3'd1;
      end
      default: state_d = NORM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= NORM;
      rcnt_q      <= 3'd0;
      head_q      <= 1'b0;
      count_q     <= 2'd0;
      valid_q     <= 2'b00;
      pred_q      <= 2'b00;
      resolved_q  <= 2'b00;
      taken_q     <= 2'b00;
      pc_q[0]     <= 16'h0000;
      pc_q[1]     <= 16'h0000;
      target_q[0] <= 16'h0000;
      target_q[1] <= 16'h0000;
      decr_q      <= 1'b0;
      mnum_q      <= 1'b0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= 16'h0000;
      upd_vld_q   <= 1'b0;
      upd_pc_q    <= 16'h0000;
      upd_taken_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      head_q      <= head_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      pred_q      <= pred_d;
      resolved_q  <= resolved_d;
      taken_q     <= taken_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      decr_q      <= decr_d;
      mnum_q      <= mnum_d;
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
      upd_vld_q   <= upd_vld_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      drop_q      <= drop_d;
    end
  end

  assign decr_count      = decr_q;
  assign mispred_num     = mnum_q;
  assign redirect_vld    = redir_vld_q;
  assign redirect_pc     = redir_pc_q;
  assign stall_fetch     = (state_q == RECOV);
  assign full            = (count_q == 2'd2);
  assign bpred_upd_vld   = upd_vld_q;
  assign bpred_upd_pc    = upd_pc_q;
  assign bpred_upd_taken = upd_taken_q;
  assign alloc_drop      = drop_q;

endmodule
